// File: rtl/mem_io_bridge.sv
// Load/store unit between the ALU stage and the word-wide data memory: decodes memory vs. MMIO,
// extracts/extends sub-word loads and turns byte/half stores into a 2-cycle read-modify-write.
module mem_io_bridge #(
    parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
    parameter int unsigned LED_W   = 16,
    parameter int unsigned SW_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr_in,
    input  logic             mRead,
    input  logic             mWrite,
    input  logic [2:0]       funct3,
    input  logic [31:0]      store_data,
    input  logic [31:0]      m_rdata,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [31:0]      r_wdata,
    output logic             stall,
    output logic             misalign,
    input  logic [SW_W-1:0]  sw_in,
    input  logic             btn_in,
    output logic [LED_W-1:0] led_out,
    output logic [31:0]      seg_out
);

    typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

    localparam logic [31:0] OffLed = 32'h00;
    localparam logic [31:0] OffSeg = 32'h04;
    localparam logic [31:0] OffSw  = 32'h10;
    localparam logic [31:0] OffBtn = 32'h14;

    state_e            state_q, state_d;
    logic [31:0]       merged_q, merged_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic [31:0]       seg_q, seg_d;
    logic [SW_W-1:0]   sw_s1_q, sw_s2_q;
    logic              btn_s1_q, btn_s2_q, btn_prev_q;
    logic              btn_flag_q, btn_flag_d;

    logic        io_sel, mem_sel, size_ok, aligned, idle, ok_acc;
    logic        is_load, is_store, rmw_start, mem_sw, io_wr, io_rd;
    logic [31:0] io_off, io_rdata, mem_ldata;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign io_sel  = (addr_in >= IO_BASE);
    assign mem_sel = ~io_sel;
    assign io_off  = addr_in - IO_BASE;

    // funct3[1:0]: 00 byte, 01 half, otherwise word
    always_comb begin
        size_ok = (addr_in[1:0] == 2'b00);
        if (funct3[1:0] == 2'b00) begin
            size_ok = 1'b1;
        end else if (funct3[1:0] == 2'b01) begin
            size_ok = ~addr_in[0];
        end
    end

    assign aligned  = io_sel ? ((funct3 == 3'b010) && (addr_in[1:0] == 2'b00)) : size_ok;
    assign idle     = ~rst && (state_q == StIdle);
    assign ok_acc   = idle && aligned;
    assign is_store = mWrite;
    assign is_load  = mRead && !mWrite;

    assign rmw_start = ok_acc && mem_sel && is_store && !funct3[1];
    assign mem_sw    = ok_acc && mem_sel && is_store && funct3[1];
    assign io_wr     = ok_acc && io_sel && is_store;
    assign io_rd     = ok_acc && io_sel && is_load;

    assign byte_v = m_rdata[{addr_in[1:0], 3'b000} +: 8];
    assign half_v = m_rdata[{addr_in[1], 4'b0000} +: 16];

    always_comb begin
        unique case (funct3)
            3'b000:  mem_ldata = {{24{byte_v[7]}}, byte_v};
            3'b001:  mem_ldata = {{16{half_v[15]}}, half_v};
            3'b100:  mem_ldata = {24'b0, byte_v};
            3'b101:  mem_ldata = {16'b0, half_v};
            default: mem_ldata = m_rdata;
        endcase
    end

    always_comb begin
        io_rdata = 32'b0;
        if (io_off == OffLed) io_rdata = 32'(led_q);
        if (io_off == OffSeg) io_rdata = seg_q;
        if (io_off == OffSw)  io_rdata = 32'(sw_s2_q);
        if (io_off == OffBtn) io_rdata = {31'b0, btn_flag_q};
    end

    always_comb begin
        state_d    = rmw_start ? StRmwWr : StIdle;
        merged_d   = merged_q;
        led_d      = led_q;
        seg_d      = seg_q;
        btn_flag_d = btn_flag_q;
        if (rmw_start) begin
            merged_d = m_rdata;
            if (!funct3[0]) begin
                merged_d[{addr_in[1:0], 3'b000} +: 8] = store_data[7:0];
            end else begin
                merged_d[{addr_in[1], 4'b0000} +: 16] = store_data[15:0];
            end
        end
        if (io_wr && (io_off == OffLed)) led_d = store_data[LED_W-1:0];
        if (io_wr && (io_off == OffSeg)) seg_d = store_data;
        // A new edge wins over a clearing read so no press is lost
        if (btn_s2_q && !btn_prev_q) begin
            btn_flag_d = 1'b1;
        end else if (io_rd && (io_off == OffBtn)) begin
            btn_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            merged_q   <= '0;
            led_q      <= '0;
            seg_q      <= '0;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            btn_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            merged_q   <= merged_d;
            led_q      <= led_d;
            seg_q      <= seg_d;
            sw_s1_q    <= sw_in;
            sw_s2_q    <= sw_s1_q;
            btn_s1_q   <= btn_in;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
            btn_flag_q <= btn_flag_d;
        end
    end

    assign mem_addr  = {addr_in[31:2], 2'b00};
    assign mem_read  = idle && mem_sel && (mRead || rmw_start);
    assign mem_write = (~rst && (state_q == StRmwWr)) || mem_sw;
    assign mem_wdata = (state_q == StRmwWr) ? merged_q : store_data;
    assign stall     = rmw_start;
    assign misalign  = idle && (mRead || mWrite) && !aligned;
    assign r_wdata   = (ok_acc && is_load) ? (io_sel ? io_rdata : mem_ldata) : 32'b0;
    assign led_out   = led_q;
    assign seg_out   = seg_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge with a small word-wide memory model behind it.
module tb_mem_io_bridge;

    localparam logic [31:0] IoBase = 32'hFFFF_FC00;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_in, store_data, m_rdata, mem_addr, mem_wdata, r_wdata, seg_out;
    logic        mRead, mWrite, mem_read, mem_write, stall, misalign, btn_in;
    logic [2:0]  funct3;
    logic [15:0] sw_in, led_out;
    logic [31:0] mem [1024];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_io_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .addr_in    (addr_in),
        .mRead      (mRead),
        .mWrite     (mWrite),
        .funct3     (funct3),
        .store_data (store_data),
        .m_rdata    (m_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .r_wdata    (r_wdata),
        .stall      (stall),
        .misalign   (misalign),
        .sw_in      (sw_in),
        .btn_in     (btn_in),
        .led_out    (led_out),
        .seg_out    (seg_out)
    );

    assign m_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;
    end

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] exp_r;
        logic        exp_mis;
        logic        exp_mw;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd);
        mRead = rd; mWrite = wr; funct3 = f3; addr_in = addr; store_data = sd;
    endtask

    function automatic vec_t mk(input string n, input logic rd, input logic wr,
                                input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                                input logic [31:0] er, input logic em, input logic ew);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.sd = sd;
        v.exp_r = er; v.exp_mis = em; v.exp_mw = ew;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk("lb_10",    1, 0, 3'b000, 32'h10, 0, 32'hFFFF_FFF1, 0, 0);
        vecs[1]  = mk("lbu_10",   1, 0, 3'b100, 32'h10, 0, 32'h0000_00F1, 0, 0);
        vecs[2]  = mk("lh_12",    1, 0, 3'b001, 32'h12, 0, 32'hFFFF_8765, 0, 0);
        vecs[3]  = mk("lhu_12",   1, 0, 3'b101, 32'h12, 0, 32'h0000_8765, 0, 0);
        vecs[4]  = mk("lw_10",    1, 0, 3'b010, 32'h10, 0, 32'h8765_43F1, 0, 0);
        vecs[5]  = mk("lb_13",    1, 0, 3'b000, 32'h13, 0, 32'hFFFF_FF87, 0, 0);
        vecs[6]  = mk("lbu_11",   1, 0, 3'b100, 32'h11, 0, 32'h0000_0043, 0, 0);
        vecs[7]  = mk("lh_10",    1, 0, 3'b001, 32'h10, 0, 32'h0000_43F1, 0, 0);
        vecs[8]  = mk("lw_mis",   1, 0, 3'b010, 32'h22, 0, 32'h0, 1, 0);
        vecs[9]  = mk("sh_mis",   0, 1, 3'b001, 32'h23, 32'h5555, 32'h0, 1, 0);
        vecs[10] = mk("lh_mis",   1, 0, 3'b001, 32'h11, 0, 32'h0, 1, 0);
        vecs[11] = mk("lw_20",    1, 0, 3'b010, 32'h20, 0, 32'h1122_3344, 0, 0);
        vecs[12] = mk("rdwr_sw",  1, 1, 3'b010, 32'h30, 32'h0BAD_F00D, 32'h0, 0, 1);
        vecs[13] = mk("io_lb",    1, 0, 3'b000, IoBase, 0, 32'h0, 1, 0);
        vecs[14] = mk("none",     0, 0, 3'b010, 32'h10, 0, 32'h0, 0, 0);

        rst = 1'b1; sw_in = '0; btn_in = 1'b0;
        drive(0, 0, 3'b010, 0, 0);
        #2;
        chk("rst_led", 32'(led_out), 0);
        chk("rst_seg", seg_out, 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_mw", 32'(mem_write), 0);
        chk("rst_mis", 32'(misalign), 0);
        @(negedge clk); rst = 1'b0;

        // Preload memory through single-cycle sw
        drive(0, 1, 3'b010, 32'h10, 32'h8765_43F1);
        #2; chk("sw_mw", 32'(mem_write), 1); chk("sw_stall", 32'(stall), 0);
        chk("sw_wdata", mem_wdata, 32'h8765_43F1);
        @(negedge clk); drive(0, 1, 3'b010, 32'h20, 32'h1122_3344);
        @(negedge clk); drive(0, 1, 3'b010, 32'h40, 32'h5566_7788);
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].sd);
            #2;
            chk({vecs[i].name, "_rdata"}, r_wdata, vecs[i].exp_r);
            chk({vecs[i].name, "_mis"}, 32'(misalign), 32'(vecs[i].exp_mis));
            chk({vecs[i].name, "_mw"}, 32'(mem_write), 32'(vecs[i].exp_mw));
            chk({vecs[i].name, "_stall"}, 32'(stall), 0);
            chk({vecs[i].name, "_maddr"}, mem_addr, vecs[i].addr & 32'hFFFF_FFFC);
            @(negedge clk);
        end

        // sb read-modify-write
        drive(0, 1, 3'b000, 32'h21, 32'h0000_00AB);
        #2;
        chk("sb_c1_stall", 32'(stall), 1);
        chk("sb_c1_mr", 32'(mem_read), 1);
        chk("sb_c1_mw", 32'(mem_write), 0);
        @(posedge clk); #1;
        chk("sb_c2_stall", 32'(stall), 0);
        chk("sb_c2_mw", 32'(mem_write), 1);
        chk("sb_c2_mr", 32'(mem_read), 0);
        chk("sb_c2_wdata", mem_wdata, 32'h1122_AB44);
        @(negedge clk); @(negedge clk);
        chk("sb_c3_mw", 32'(mem_write), 0);
        drive(1, 0, 3'b010, 32'h20, 0);
        #2; chk("sb_lw", r_wdata, 32'h1122_AB44);
        @(negedge clk);

        // sh upper half
        drive(0, 1, 3'b001, 32'h22, 32'hFFFF_CDEF);
        @(posedge clk); #1; chk("sh_wdata", mem_wdata, 32'hCDEF_AB44);
        @(negedge clk); @(negedge clk);

        // LED / SEG
        drive(0, 1, 3'b010, IoBase, 32'hDEAD_BEEF);
        #2; chk("io_mw", 32'(mem_write), 0);
        @(posedge clk); #1; chk("led", 32'(led_out), 32'h0000_BEEF);
        @(negedge clk); drive(0, 1, 3'b010, IoBase + 4, 32'hCAFE_F00D);
        @(posedge clk); #1; chk("seg", seg_out, 32'hCAFE_F00D);
        @(negedge clk); drive(0, 1, 3'b000, IoBase, 32'h1);
        #2; chk("io_sb_mis", 32'(misalign), 1);
        @(posedge clk); #1; chk("io_sb_led", 32'(led_out), 32'h0000_BEEF);
        @(negedge clk); drive(1, 0, 3'b010, IoBase, 0);
        #2; chk("led_rd", r_wdata, 32'h0000_BEEF);
        @(negedge clk); drive(1, 0, 3'b010, IoBase + 4, 0);
        #2; chk("seg_rd", r_wdata, 32'hCAFE_F00D);
        @(negedge clk); drive(1, 0, 3'b010, IoBase + 8, 0);
        #2; chk("io_hole", r_wdata, 0);

        // Switch synchronizer
        @(negedge clk); sw_in = 16'h1234; drive(1, 0, 3'b010, IoBase + 32'h10, 0);
        #2; chk("sw_0clk", r_wdata, 0);
        @(posedge clk); #1; chk("sw_1clk", r_wdata, 0);
        @(posedge clk); #1; chk("sw_2clk", r_wdata, 32'h1234);

        // Button pulse, then read-and-clear
        @(negedge clk); drive(0, 0, 3'b010, 0, 0); btn_in = 1'b1;
        repeat (3) @(negedge clk);
        btn_in = 1'b0;
        repeat (3) @(negedge clk);
        drive(1, 0, 3'b010, IoBase + 32'h14, 0);
        #2; chk("btn_rd1", r_wdata, 1);
        @(negedge clk); #2; chk("btn_rd2", r_wdata, 0);

        // Rising edge coincident with the clearing read
        @(negedge clk); drive(0, 0, 3'b010, 0, 0); btn_in = 1'b1;
        @(negedge clk); @(negedge clk);
        drive(1, 0, 3'b010, IoBase + 32'h14, 0);
        #2; chk("btn_co1", r_wdata, 0);
        @(negedge clk); #2; chk("btn_co2", r_wdata, 1);
        @(negedge clk); #2; chk("btn_co3", r_wdata, 0);
        btn_in = 1'b0;

        // Reset during RMW_WR drops the store
        @(negedge clk); drive(0, 1, 3'b000, 32'h40, 32'h0000_00AB);
        @(posedge clk); #1; chk("rr_mw_pre", 32'(mem_write), 1);
        rst = 1'b1;
        #1;
        chk("rr_mw", 32'(mem_write), 0);
        chk("rr_stall", 32'(stall), 0);
        chk("rr_led", 32'(led_out), 0);
        chk("rr_seg", seg_out, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0; drive(1, 0, 3'b010, 32'h40, 0);
        #2; chk("rr_mem", r_wdata, 32'h5566_7788);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
